// File: rtl/adc_axis_packer_pkg.sv
// Shared definitions for the AD7928 frame packer.
//   FRAME_W / field positions : layout of one 16-bit AD7928 read frame
//   slot_t                    : buffered {chan, 12-bit data} for one lane
//   decode_frame()            : frame -> slot_t
//   pack_word()               : {adc_idx, chan, sample} left-justified sample, zero pad above
package adc7928_pkg;

  localparam int unsigned FRAME_W    = 16;
  localparam int unsigned CH_ADDR_W  = 3;
  localparam int unsigned ZERO_BIT   = 15;
  localparam int unsigned CH_MSB     = 14;
  localparam int unsigned CH_LSB     = 12;
  localparam int unsigned DATA_MSB   = 11;
  localparam int unsigned WORD_MAX_W = 64;

  typedef logic [WORD_MAX_W-1:0] word_t;

  typedef struct packed {
    logic [CH_ADDR_W-1:0] chan;
    logic [DATA_MSB:0]    data;
  } slot_t;

  function automatic slot_t decode_frame(input logic [FRAME_W-1:0] f);
    slot_t s;
    s.chan = f[CH_MSB:CH_LSB];
    s.data = f[DATA_MSB:0];
    return s;
  endfunction

  // The full 12-bit field is kept in the slot; the sample is cut to its top
  // dout_w bits here so the slot type does not depend on DOUT_WIDTH.
  function automatic word_t pack_word(input int unsigned idx, input slot_t s,
                                      input int unsigned dout_w);
    word_t w;
    w = word_t'(s.data >> (DATA_MSB + 1 - dout_w));
    w = w | (word_t'(s.chan) << dout_w);
    w = w | (word_t'(idx) << (dout_w + CH_ADDR_W));
    return w;
  endfunction

endpackage

// File: rtl/adc_axis_packer_if.sv
// AXI-Stream bundle for the packer output.
//   tdata/tvalid/tlast : master -> slave
//   tready             : slave -> master
interface adc_axis_packer_if #(
  parameter int unsigned TDATA_WIDTH = 16
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_axis_packer_rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request per lane
//   ptr     : lane with highest priority this cycle
//   gnt_idx : first requesting lane at or after ptr, wrapping to 0
//   any     : at least one request
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);
  int unsigned k;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/adc_axis_packer.sv
// Buffers one completed AD7928 frame per ADC lane and drains the lanes
// round-robin onto a single AXI-Stream master.
//   CLK, rstn   : clock, synchronous active-low reset
//   s_valid     : per-lane frame strobe, s_frame lane k = s_frame[16*k +: 16]
//   clr_status  : clears the sticky overflow flags
//   m_axis      : AXIS master {pad, adc_idx, chan, sample}, tlast on last lane
//   overflow    : sticky, frame dropped because the lane slot was occupied
//   frame_err   : one-cycle pulse, frame arrived without its leading zero
module adc_axis_packer
  import adc7928_pkg::*;
#(
  parameter int unsigned DOUT_WIDTH  = 8,
  parameter int unsigned NUM_OF_ADC  = 4,
  parameter int unsigned TDATA_WIDTH = 16
) (
  input  logic                          CLK,
  input  logic                          rstn,
  input  logic [NUM_OF_ADC-1:0]         s_valid,
  input  logic [NUM_OF_ADC*FRAME_W-1:0] s_frame,
  input  logic                          clr_status,
  adc_axis_packer_if.master             m_axis,
  output logic [NUM_OF_ADC-1:0]         overflow,
  output logic [NUM_OF_ADC-1:0]         frame_err
);
  localparam int unsigned IDX_W = $clog2(NUM_OF_ADC);

  if (NUM_OF_ADC < 2 || DOUT_WIDTH < 1 || DOUT_WIDTH > 12 ||
      TDATA_WIDTH < IDX_W + CH_ADDR_W + DOUT_WIDTH) begin : g_cfg_err
    $error("adc_axis_packer: illegal DOUT_WIDTH/NUM_OF_ADC/TDATA_WIDTH combination");
  end

  typedef enum logic {ST_EMPTY, ST_HOLD} out_state_e;

  out_state_e             state_q, state_d;
  logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_OF_ADC-1:0]  full_q, full_d;
  logic [NUM_OF_ADC-1:0]  overflow_q, overflow_d;
  logic [NUM_OF_ADC-1:0]  frame_err_q, frame_err_d;
  slot_t                  slot_q [NUM_OF_ADC];
  slot_t                  slot_d [NUM_OF_ADC];

  logic             load_en;
  logic             any;
  logic [IDX_W-1:0] gnt_idx;

  rr_arbiter #(.N(NUM_OF_ADC), .IDX_W(IDX_W)) u_arb (
    .req     (full_q),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign load_en = (state_q == ST_EMPTY) || m_axis.tready;

  // Output stage: a slot drains only when the output register is free or
  // its word is being accepted, which keeps tdata/tlast stable under stall.
  always_comb begin
    state_d   = state_q;
    m_tdata_d = m_tdata_q;
    m_tlast_d = m_tlast_q;
    ptr_d     = ptr_q;
    if (load_en) begin
      if (any) begin
        state_d   = ST_HOLD;
        m_tdata_d = TDATA_WIDTH'(pack_word(32'(gnt_idx), slot_q[gnt_idx], DOUT_WIDTH));
        m_tlast_d = (gnt_idx == IDX_W'(NUM_OF_ADC - 1));
        ptr_d     = (gnt_idx == IDX_W'(NUM_OF_ADC - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Slot capture: a lane drained on this edge may accept a new frame on the
  // same edge, so the refill check uses the drain decision, not full_q alone.
  logic [FRAME_W-1:0] lane_frame;
  logic               lane_drain;

  always_comb begin
    full_d      = full_q;
    slot_d      = slot_q;
    overflow_d  = clr_status ? '0 : overflow_q;
    frame_err_d = '0;
    lane_frame  = '0;
    lane_drain  = 1'b0;
    for (int unsigned k = 0; k < NUM_OF_ADC; k++) begin
      lane_frame = s_frame[FRAME_W*k +: FRAME_W];
      lane_drain = load_en && any && (32'(gnt_idx) == k);
      if (lane_drain) full_d[k] = 1'b0;
      if (s_valid[k]) begin
        if (lane_frame[ZERO_BIT]) begin
          frame_err_d[k] = 1'b1;
        end else if (!full_q[k] || lane_drain) begin
          full_d[k] = 1'b1;
          slot_d[k] = decode_frame(lane_frame);
        end else begin
          overflow_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state_q     <= ST_EMPTY;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      ptr_q       <= '0;
      full_q      <= '0;
      overflow_q  <= '0;
      frame_err_q <= '0;
    end else begin
      state_q     <= state_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    slot_q <= slot_d;
  end

  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = (state_q == ST_HOLD);
  assign m_axis.tlast  = m_tlast_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_adc_axis_packer.sv
// Self-checking bench for adc_axis_packer (DOUT_WIDTH=8, NUM_OF_ADC=4, TDATA_WIDTH=16).
module tb_adc_axis_packer;

  typedef struct {
    logic [15:0] tdata;
    logic        tlast;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rstn;
  logic [3:0]  s_valid;
  logic [63:0] s_frame;
  logic        clr_status;
  logic [3:0]  overflow;
  logic [3:0]  frame_err;

  int tests_run = 0;
  int fails     = 0;
  int hs_count  = 0;
  exp_t sbq[$];

  adc_axis_packer_if #(.TDATA_WIDTH(16)) axis ();

  adc_axis_packer #(.DOUT_WIDTH(8), .NUM_OF_ADC(4), .TDATA_WIDTH(16)) dut (
    .CLK        (CLK),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_frame    (s_frame),
    .clr_status (clr_status),
    .m_axis     (axis),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  // Word layout: adc_idx [12:11], chan [10:8], sample [7:0] = frame[11:4]
  function automatic logic [15:0] exp_word(input logic [1:0] idx, input logic [15:0] f);
    logic [15:0] w;
    w        = '0;
    w[12:11] = idx;
    w[10:8]  = f[14:12];
    w[7:0]   = f[11:4];
    return w;
  endfunction

  task automatic push_exp(input logic [1:0] idx, input logic [15:0] f);
    exp_t e;
    e.tdata = exp_word(idx, f);
    e.tlast = (idx == 2'd3);
    sbq.push_back(e);
  endtask

  // Handshake happens at the next posedge iff tvalid && tready here, since
  // inputs only change 1 time unit after a posedge.
  always @(negedge CLK) begin
    if (rstn && axis.tvalid && axis.tready) begin
      exp_t e;
      hs_count++;
      tests_run++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_unexpected: got tdata=%h tlast=%b, required no word",
                 axis.tdata, axis.tlast);
      end else begin
        e = sbq.pop_front();
        if (axis.tdata !== e.tdata || axis.tlast !== e.tlast) begin
          fails++;
          $display("FAIL scoreboard_word: got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                   axis.tdata, axis.tlast, e.tdata, e.tlast);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    rstn       = 1'b0;
    s_valid    = '0;
    clr_status = 1'b0;
    tick();
    rstn = 1'b1;
    sbq.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    axis.tready = 1'b1;
    s_frame     = '0;
    rstn        = 1'b0;
    s_valid     = '0;
    clr_status  = 1'b0;
    tick();
    tick();
    tests_run++;
    if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b, required 0", axis.tvalid); end
    tests_run++;
    if (axis.tdata !== 16'h0000) begin fails++; $display("FAIL reset_tdata: got %h, required 0000", axis.tdata); end
    tests_run++;
    if (axis.tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b, required 0", axis.tlast); end
    tests_run++;
    if (overflow !== 4'b0000) begin fails++; $display("FAIL reset_overflow: got %b, required 0000", overflow); end
    tests_run++;
    if (frame_err !== 4'b0000) begin fails++; $display("FAIL reset_frame_err: got %b, required 0000", frame_err); end
    rstn = 1'b1;
  endtask

  task automatic drive_four(input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3);
    s_frame = {f3, f2, f1, f0};
    s_valid = 4'b1111;
    push_exp(2'd0, f0);
    push_exp(2'd1, f1);
    push_exp(2'd2, f2);
    push_exp(2'd3, f3);
    tick();
    s_valid = '0;
  endtask

  task automatic test_all_lanes();
    apply_reset();
    axis.tready = 1'b1;
    drive_four(16'h1A50, 16'h3B60, 16'h5C70, 16'h7D80);
    tests_run++;
    if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL latency_early: tvalid got %b, required 0", axis.tvalid); end
    tick();
    tests_run++;
    if (axis.tvalid !== 1'b1) begin fails++; $display("FAIL latency: tvalid got %b, required 1", axis.tvalid); end
    repeat (4) tick();
    tests_run++;
    if (sbq.size() != 0) begin fails++; $display("FAIL back_to_back: %0d words pending, required 0", sbq.size()); end
    tests_run++;
    if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL drain_empty: tvalid got %b, required 0", axis.tvalid); end
  endtask

  task automatic test_stall();
    logic [15:0] snap_d;
    logic        snap_l;
    apply_reset();
    axis.tready = 1'b1;
    drive_four(16'h1A50, 16'h3B60, 16'h5C70, 16'h7D80);
    tick();
    tick();
    axis.tready = 1'b0;
    snap_d = axis.tdata;
    snap_l = axis.tlast;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== snap_d || axis.tlast !== snap_l) begin
        fails++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 axis.tvalid, axis.tdata, axis.tlast, snap_d, snap_l);
      end
    end
    axis.tready = 1'b1;
    wait_drain(20);
    repeat (3) tick();
    tests_run++;
    if (sbq.size() != 0) begin fails++; $display("FAIL stall_release: %0d words pending, required 0", sbq.size()); end
  endtask

  task automatic test_overflow();
    apply_reset();
    axis.tready = 1'b0;
    s_frame = {48'h0, 16'h1A50};
    s_valid = 4'b0001;
    push_exp(2'd0, 16'h1A50);
    tick();
    s_valid = '0;
    tick();
    s_frame = {16'h0, 16'h2110, 32'h0};
    s_valid = 4'b0100;
    push_exp(2'd2, 16'h2110);
    tick();
    s_frame = {16'h0, 16'h2220, 32'h0};
    tick();
    s_valid = '0;
    tests_run++;
    if (overflow !== 4'b0100) begin fails++; $display("FAIL overflow_set: got %b, required 0100", overflow); end
    axis.tready = 1'b1;
    wait_drain(20);
    repeat (3) tick();
    tests_run++;
    if (sbq.size() != 0) begin fails++; $display("FAIL overflow_words: %0d words pending, required 0", sbq.size()); end
    tests_run++;
    if (overflow !== 4'b0100) begin fails++; $display("FAIL overflow_sticky: got %b, required 0100", overflow); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    tests_run++;
    if (overflow !== 4'b0000) begin fails++; $display("FAIL overflow_clear: got %b, required 0000", overflow); end
  endtask

  task automatic test_frame_err();
    int hs0;
    apply_reset();
    axis.tready = 1'b1;
    hs0 = hs_count;
    s_frame = {32'h0, 16'h8FF0, 16'h0};
    s_valid = 4'b0010;
    tick();
    s_valid = '0;
    tests_run++;
    if (frame_err !== 4'b0010) begin fails++; $display("FAIL frame_err_pulse: got %b, required 0010", frame_err); end
    tick();
    tests_run++;
    if (frame_err !== 4'b0000) begin fails++; $display("FAIL frame_err_single: got %b, required 0000", frame_err); end
    repeat (3) tick();
    tests_run++;
    if (hs_count != hs0 || axis.tvalid !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_noword: got %0d words tvalid=%b, required 0 words tvalid=0", hs_count - hs0, axis.tvalid);
    end
    tests_run++;
    if (overflow !== 4'b0000) begin fails++; $display("FAIL frame_err_overflow: got %b, required 0000", overflow); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    axis.tready = 1'b1;
    // Lanes 0 and 3 never change content, so dropped refills do not alter the expected words.
    for (int i = 0; i < 9; i++) push_exp((i % 2 == 0) ? 2'd0 : 2'd3, (i % 2 == 0) ? 16'h1A50 : 16'h7D80);
    s_frame = {16'h7D80, 32'h0, 16'h1A50};
    for (int i = 0; i < 8; i++) begin
      s_valid = 4'b1001;
      tick();
    end
    s_valid = '0;
    wait_drain(20);
    repeat (3) tick();
    tests_run++;
    if (sbq.size() != 0) begin fails++; $display("FAIL round_robin: %0d words pending, required 0", sbq.size()); end
  endtask

  task automatic test_mid_reset();
    int hs0;
    apply_reset();
    axis.tready = 1'b0;
    s_frame = {16'h7D80, 16'h5C70, 16'h3B60, 16'h1A50};
    s_valid = 4'b0111;
    tick();
    s_valid = 4'b0010;
    tick();
    s_valid = '0;
    tests_run++;
    if (axis.tvalid !== 1'b1 || overflow !== 4'b0010) begin
      fails++;
      $display("FAIL mid_reset_setup: got tvalid=%b ovf=%b, required tvalid=1 ovf=0010", axis.tvalid, overflow);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tests_run++;
    if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL mid_reset_tvalid: got %b, required 0", axis.tvalid); end
    tests_run++;
    if (overflow !== 4'b0000) begin fails++; $display("FAIL mid_reset_overflow: got %b, required 0000", overflow); end
    axis.tready = 1'b1;
    hs0 = hs_count;
    repeat (10) tick();
    tests_run++;
    if (hs_count != hs0) begin fails++; $display("FAIL mid_reset_stale: got %0d words, required 0", hs_count - hs0); end
  endtask

  initial begin
    test_reset();
    test_all_lanes();
    test_stall();
    test_overflow();
    test_frame_err();
    test_round_robin();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
